// File: rtl/key_debounce_pulse_if.sv
// Push-button bus: raw active-low keys in, debounced level/pulses and press count out.
interface key_debounce_pulse_if #(
    parameter int unsigned NKEYS = 4
);

    logic [NKEYS-1:0] KEY;
    logic [NKEYS-1:0] key_level;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic [7:0]       press_count;

    // Key source side (board / bench).
    modport master (
        output KEY,
        input  key_level,
        input  key_press,
        input  key_release,
        input  press_count
    );

    // Debouncer side.
    modport slave (
        input  KEY,
        output key_level,
        output key_press,
        output key_release,
        output press_count
    );

endinterface

// File: rtl/key_debounce_pulse.sv
// Multi-channel push-button debouncer with press/release pulses and a channel-0 press counter.
// Raw keys are synchronized, inverted to active-high, and each channel must hold a new
// value for DEBOUNCE_CYCLES consecutive samples before the debounced level follows it.
module key_debounce_pulse #(
    parameter int unsigned NKEYS           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    key_debounce_pulse_if.slave bus
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } state_t;

    logic [NKEYS-1:0] meta_q;
    logic [NKEYS-1:0] sync_q;
    logic [NKEYS-1:0] key_sync;
    logic [NKEYS-1:0] key_level_w;
    logic [NKEYS-1:0] key_press_w;
    logic [NKEYS-1:0] key_release_w;
    logic [7:0]       press_count_q;

    // Two-flop synchronizer; resets to the released (high) raw level so a held key re-qualifies.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= bus.KEY;
            sync_q <= meta_q;
        end
    end

    assign key_sync = ~sync_q;

    for (genvar g = 0; g < NKEYS; g++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             accept_press;
        logic             accept_release;

        assign accept_press   = (state_q == ST_WAIT_DOWN) && key_sync[g] && (cnt_q == CNT_LAST);
        assign accept_release = (state_q == ST_WAIT_UP) && !key_sync[g] && (cnt_q == CNT_LAST);

        // Per-channel debounce FSM; counter tracks consecutive samples of the candidate level.
        always_ff @(posedge CLOCK_50) begin
            if (!reset_n) begin
                state_q   <= ST_UP;
                cnt_q     <= CNT_ZERO;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= accept_press;
                release_q <= accept_release;
                case (state_q)
                    ST_UP: begin
                        if (key_sync[g]) begin
                            state_q <= ST_WAIT_DOWN;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= CNT_ZERO;
                        end
                    end
                    ST_WAIT_DOWN: begin
                        if (!key_sync[g]) begin
                            state_q <= ST_UP;
                            cnt_q   <= CNT_ZERO;
                        end else if (accept_press) begin
                            state_q <= ST_DOWN;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_DOWN: begin
                        if (!key_sync[g]) begin
                            state_q <= ST_WAIT_UP;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= CNT_ZERO;
                        end
                    end
                    ST_WAIT_UP: begin
                        if (key_sync[g]) begin
                            state_q <= ST_DOWN;
                            cnt_q   <= CNT_ZERO;
                        end else if (accept_release) begin
                            state_q <= ST_UP;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_UP;
                        cnt_q   <= CNT_ZERO;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign key_level_w[g]   = level_q;
        assign key_press_w[g]   = press_q;
        assign key_release_w[g] = release_q;

        // Press and release are exclusive, single-cycle, and match the level they produce.
        a_no_overlap : assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            !(press_q && release_q));
        a_press_one_cycle : assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            press_q |=> !press_q);
        a_release_one_cycle : assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            release_q |=> !release_q);
        a_press_level : assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            press_q |-> level_q);
        a_release_level : assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            release_q |-> !level_q);
        a_cnt_bound : assert property (@(posedge CLOCK_50) disable iff (!reset_n)
            cnt_q <= CNT_LAST);
    end

    // Channel-0 press counter, stepping on the same edge that raises key_press[0]; wraps freely.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            press_count_q <= 8'd0;
        end else if (g_ch[0].accept_press) begin
            press_count_q <= press_count_q + 8'd1;
        end
    end

    assign bus.key_level   = key_level_w;
    assign bus.key_press   = key_press_w;
    assign bus.key_release = key_release_w;
    assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse with DEBOUNCE_CYCLES=4 (pulses land 6 edges after a key change).
module tb_key_debounce_pulse;

    localparam int unsigned NK  = 4;
    localparam int unsigned DC  = 4;
    localparam int unsigned LAT = DC + 2;

    typedef struct {
        int unsigned   cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] level;
    } ev_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    logic [NK-1:0] key_raw;

    key_debounce_pulse_if #(.NKEYS(NK)) bus ();

    key_debounce_pulse #(
        .NKEYS          (NK),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Advance n rising edges, then settle just past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    // Clean key change: queue the pulse the debouncer must emit LAT edges from now.
    task automatic set_key(input logic [NK-1:0] k);
        logic [NK-1:0] chg;
        ev_t           ev;
        chg = key_raw ^ k;
        if (chg != '0) begin
            ev.cyc   = cyc + LAT;
            ev.press = chg & ~k;
            ev.rel   = chg & k;
            ev.level = ~k;
            exp_q.push_back(ev);
        end
        key_raw = k;
        bus.KEY = k;
    endtask

    // Raw drive with no expected response (bounce / reset scenarios).
    task automatic drive_raw(input logic [NK-1:0] k);
        key_raw = k;
        bus.KEY = k;
    endtask

    // Monitor: every pulse cycle must match the oldest queued expectation.
    always @(negedge CLOCK_50) begin
        if ((bus.key_press | bus.key_release) != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got press=%b release=%b level=%b at edge %0d, required none",
                         bus.key_press, bus.key_release, bus.key_level, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.press !== bus.key_press || e.rel !== bus.key_release
                    || e.level !== bus.key_level) begin
                    errors++;
                    $display("FAIL pulse_event: got edge=%0d press=%b release=%b level=%b, required edge=%0d press=%b release=%b level=%b",
                             cyc, bus.key_press, bus.key_release, bus.key_level,
                             e.cyc, e.press, e.rel, e.level);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: got no pulse by edge %0d, required press=%b release=%b at edge %0d",
                     cyc, e.press, e.rel, e.cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        drive_raw(4'hF);
        tick(3);
        chk("reset_level",   32'(bus.key_level),   32'h0);
        chk("reset_press",   32'(bus.key_press),   32'h0);
        chk("reset_release", 32'(bus.key_release), 32'h0);
        chk("reset_count",   32'(bus.press_count), 32'h0);
        reset_n = 1'b1;

        // Idle with keys released: nothing may happen for 100 cycles.
        tick(100);
        chk("idle_level", 32'(bus.key_level),   32'h0);
        chk("idle_count", 32'(bus.press_count), 32'h0);

        // Single clean press on channel 0.
        set_key(4'hE);
        tick(10);
        chk("ch0_level", 32'(bus.key_level),   32'h1);
        chk("ch0_count", 32'(bus.press_count), 32'h1);

        // Channel 2 held then cleanly released while channel 0 stays down.
        set_key(4'hA);
        tick(10);
        chk("ch2_down_level", 32'(bus.key_level), 32'h5);
        set_key(4'hE);
        tick(10);
        chk("ch2_up_level", 32'(bus.key_level), 32'h1);
        set_key(4'hF);
        tick(10);
        chk("ch0_up_level", 32'(bus.key_level), 32'h0);

        // Channel 1 bounces: 3 low samples each time, one short of acceptance.
        for (int i = 0; i < 10; i++) begin
            drive_raw(4'hD);
            tick(3);
            drive_raw(4'hF);
            tick(3);
        end
        tick(10);
        chk("bounce_level", 32'(bus.key_level), 32'h0);

        // Channels 0 and 3 pressed together, then released together.
        set_key(4'h6);
        tick(10);
        chk("dual_level", 32'(bus.key_level),   32'h9);
        chk("dual_count", 32'(bus.press_count), 32'h2);
        set_key(4'hF);
        tick(10);

        // 254 more presses on channel 0 bring the counter through 255 and back to 0.
        for (int i = 0; i < 254; i++) begin
            set_key(4'hE);
            tick(8);
            set_key(4'hF);
            tick(8);
            if (i == 252) chk("count_255", 32'(bus.press_count), 32'hFF);
        end
        chk("count_wrap", 32'(bus.press_count), 32'h0);
        tick(5);

        // Reset in the middle of a debounce (counter at 2) with key 0 still held.
        drive_raw(4'hE);
        tick(4);
        reset_n = 1'b0;
        tick(2);
        chk("midreset_level", 32'(bus.key_level), 32'h0);
        chk("midreset_press", 32'(bus.key_press), 32'h0);
        chk("midreset_count", 32'(bus.press_count), 32'h0);
        reset_n = 1'b1;
        begin
            ev_t ev;
            ev.cyc   = cyc + LAT;
            ev.press = 4'h1;
            ev.rel   = 4'h0;
            ev.level = 4'h1;
            exp_q.push_back(ev);
        end
        tick(10);
        chk("postreset_level", 32'(bus.key_level),   32'h1);
        chk("postreset_count", 32'(bus.press_count), 32'h1);
        set_key(4'hF);
        tick(10);
        chk("final_level", 32'(bus.key_level), 32'h0);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
